// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, loader-writable instruction memory and
// the IF/ID pipeline register, with stall, redirect, loader and HLT handling.
module fetch_stage #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable_fm,
    input  logic [31:0] write_addr_fm,
    input  logic [15:0] write_data_fm,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [15:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus1,
    output logic        valid,
    output logic        halted
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [4:0] OP_HLT = 5'b00001;
    localparam logic [15:0] NOP   = 16'h0000;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        LOAD
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [15:0] instruction_next;
    logic [31:0] pc_out_next;
    logic [31:0] pc_plus1_next;
    logic        valid_next;

    logic [15:0] mem [DEPTH];
    logic [15:0] fetch_word;
    logic        write_in_range;

    assign write_in_range = (write_addr_fm >> ADDR_W) == 32'd0;
    assign fetch_word     = mem[pc[ADDR_W-1:0]];

    // Memory has no reset so the loaded program image survives a processor reset.
    always_ff @(posedge clk) begin
        if (write_enable_fm && write_in_range) begin
            mem[write_addr_fm[ADDR_W-1:0]] <= write_data_fm;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instruction_next = instruction;
        pc_out_next      = pc_out;
        pc_plus1_next    = pc_plus1;
        valid_next       = valid;

        if (write_enable_fm) begin
            state_next       = LOAD;
            instruction_next = NOP;
            valid_next       = 1'b0;
        end else if (redirect_en) begin
            state_next       = RUN;
            pc_next          = redirect_pc;
            instruction_next = NOP;
            valid_next       = 1'b0;
        end else if (state == HALT) begin
            instruction_next = NOP;
            valid_next       = 1'b0;
        end else if (stall) begin
            // LOAD with the strobe gone always falls back to RUN, even while stalled.
            state_next = RUN;
        end else begin
            instruction_next = fetch_word;
            pc_out_next      = pc;
            pc_plus1_next    = pc + 32'd1;
            valid_next       = 1'b1;
            pc_next          = pc + 32'd1;
            state_next       = (fetch_word[15:11] == OP_HLT) ? HALT : RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instruction <= NOP;
            pc_out      <= 32'd0;
            pc_plus1    <= 32'd0;
            valid       <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instruction_next;
            pc_out      <= pc_out_next;
            pc_plus1    <= pc_plus1_next;
            valid       <= valid_next;
        end
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed boot/stall/redirect/halt/loader/reset
// sequences followed by random traffic, all compared against a behavioural model.
module tb_fetch_stage;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk;
    logic        reset;
    logic        write_enable_fm;
    logic [31:0] write_addr_fm;
    logic [15:0] write_data_fm;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [15:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus1;
    logic        valid;
    logic        halted;

    int check_count = 0;
    int pass_count  = 0;

    // Behavioural model of the programmer-visible state
    logic [15:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [15:0] m_instr;
    logic [31:0] m_pc_out;
    logic [31:0] m_pc_plus1;
    logic        m_valid;
    logic        m_halted;

    fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'd32)) dut (
        .clk            (clk),
        .reset          (reset),
        .write_enable_fm(write_enable_fm),
        .write_addr_fm  (write_addr_fm),
        .write_data_fm  (write_data_fm),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .instruction    (instruction),
        .pc_out         (pc_out),
        .pc_plus1       (pc_plus1),
        .valid          (valid),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected)
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        else
            pass_count++;
    endtask

    task automatic modelReset();
        m_pc       = 32'd32;
        m_instr    = 16'h0000;
        m_pc_out   = 32'd0;
        m_pc_plus1 = 32'd0;
        m_valid    = 1'b0;
        m_halted   = 1'b0;
    endtask

    // One rising edge of the model, following the priority order of the fetch stage.
    task automatic modelEdge(input logic rst, input logic we, input logic [31:0] waddr,
                             input logic [15:0] wdata, input logic stl, input logic redir,
                             input logic [31:0] rpc);
        logic [15:0] word;
        word = m_mem[m_pc % DEPTH];
        if (!rst) begin
            modelReset();
        end else if (we) begin
            m_instr  = 16'h0000;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (redir) begin
            m_pc     = rpc;
            m_instr  = 16'h0000;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end else if (!stl) begin
            m_instr    = word;
            m_pc_out   = m_pc;
            m_pc_plus1 = m_pc + 1;
            m_valid    = 1'b1;
            m_pc       = m_pc + 1;
            m_halted   = (word[15:11] == 5'd1);
        end
        if (we && waddr < DEPTH)
            m_mem[waddr] = wdata;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_instr"}, {16'h0, instruction}, {16'h0, m_instr});
        checkOutput({tag, "_pc_out"}, pc_out, m_pc_out);
        checkOutput({tag, "_pc_plus1"}, pc_plus1, m_pc_plus1);
        checkOutput({tag, "_valid"}, {31'h0, valid}, {31'h0, m_valid});
        checkOutput({tag, "_halted"}, {31'h0, halted}, {31'h0, m_halted});
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare shortly after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic we,
                                 input logic [31:0] waddr, input logic [15:0] wdata,
                                 input logic stl, input logic redir, input logic [31:0] rpc);
        reset           = rst;
        write_enable_fm = we;
        write_addr_fm   = waddr;
        write_data_fm   = wdata;
        stall           = stl;
        redirect_en     = redir;
        redirect_pc     = rpc;
        @(posedge clk);
        modelEdge(rst, we, waddr, wdata, stl, redir, rpc);
        #1;
        compareAll(tag);
    endtask

    task automatic stepRun(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 32'd0, 16'h0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [15:0] data;
        reset = 1'b0;
        write_enable_fm = 1'b0;
        write_addr_fm = 32'd0;
        write_data_fm = 16'h0;
        stall = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'd0;
        modelReset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;

        // Load the whole image while reset is held low
        for (int i = 0; i < DEPTH; i++) begin
            data = 16'($urandom);
            if (data[15:11] == 5'd1) data[15] = 1'b1;
            case (i)
                32'h00:  data = 16'h3000;
                32'h20:  data = 16'h415F;
                32'h21:  data = 16'h495F;
                32'h22:  data = 16'hCA5F;
                32'h23:  data = 16'h0800;
                32'h40:  data = 16'h1234;
                32'h41:  data = 16'h5678;
                32'h3FF: data = 16'h2000;
                default: ;
            endcase
            applyStimulus("load", 1'b0, 1'b1, i, data, 1'b0, 1'b0, 32'd0);
        end
        checkOutput("reset_valid", {31'h0, valid}, 32'd0);

        stepRun("boot0");
        checkOutput("boot0_word", {16'h0, instruction}, 32'h415F);
        checkOutput("boot0_pc", pc_out, 32'h20);
        stepRun("boot1");
        checkOutput("boot1_word", {16'h0, instruction}, 32'h495F);

        for (int k = 0; k < 3; k++) begin
            applyStimulus("stall", 1'b1, 1'b0, 32'd0, 16'h0, 1'b1, 1'b0, 32'd0);
            checkOutput("stall_hold", {16'h0, instruction}, 32'h495F);
        end
        stepRun("after_stall");
        checkOutput("after_stall_word", {16'h0, instruction}, 32'hCA5F);
        checkOutput("after_stall_pc", pc_out, 32'h22);

        // HLT stalled first, then latched
        applyStimulus("hlt_stall", 1'b1, 1'b0, 32'd0, 16'h0, 1'b1, 1'b0, 32'd0);
        checkOutput("hlt_stall_halted", {31'h0, halted}, 32'd0);
        stepRun("hlt");
        checkOutput("hlt_word", {16'h0, instruction}, 32'h0800);
        checkOutput("hlt_valid", {31'h0, valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            stepRun("halted");
            checkOutput("halted_flag", {31'h0, halted}, 32'd1);
        end
        applyStimulus("redir_halt", 1'b1, 1'b0, 32'd0, 16'h0, 1'b0, 1'b1, 32'h20);
        checkOutput("redir_halt_flag", {31'h0, halted}, 32'd0);
        stepRun("rehalt0");
        checkOutput("rehalt0_word", {16'h0, instruction}, 32'h415F);

        // Redirect wins over stall
        applyStimulus("redir_stall", 1'b1, 1'b0, 32'd0, 16'h0, 1'b1, 1'b1, 32'h40);
        checkOutput("redir_bubble", {16'h0, instruction}, 32'h0000);
        stepRun("redir_tgt");
        checkOutput("redir_tgt_word", {16'h0, instruction}, 32'h1234);
        checkOutput("redir_tgt_pc", pc_out, 32'h40);
        stepRun("redir_next");

        // Loader mid-program: write at the current PC, then out of range
        applyStimulus("ld_cur", 1'b1, 1'b1, 32'h42, 16'hBEEF, 1'b0, 1'b0, 32'd0);
        applyStimulus("ld_oor", 1'b1, 1'b1, DEPTH, 16'hFFFF, 1'b0, 1'b0, 32'd0);
        stepRun("ld_resume");
        checkOutput("ld_resume_word", {16'h0, instruction}, 32'hBEEF);
        checkOutput("ld_resume_pc", pc_out, 32'h42);

        // PC wrap at 2^32, index wrap, and out-of-range write left word 0 intact
        applyStimulus("wrap_redir", 1'b1, 1'b0, 32'd0, 16'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        stepRun("wrap_top");
        checkOutput("wrap_top_word", {16'h0, instruction}, 32'h2000);
        checkOutput("wrap_top_plus1", pc_plus1, 32'd0);
        stepRun("wrap_zero");
        checkOutput("wrap_zero_word", {16'h0, instruction}, 32'h3000);
        checkOutput("wrap_zero_pc", pc_out, 32'd0);

        // Asynchronous reset between edges
        #3;
        reset = 1'b0;
        #1;
        modelReset();
        compareAll("async_rst");
        applyStimulus("rst_hold", 1'b0, 1'b0, 32'd0, 16'h0, 1'b0, 1'b0, 32'd0);
        stepRun("rst_boot");
        checkOutput("rst_boot_word", {16'h0, instruction}, 32'h415F);
        checkOutput("rst_boot_pc", pc_out, 32'h20);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic r_rst, r_we, r_stl, r_redir;
            logic [31:0] r_addr, r_rpc;
            r_rst   = ($urandom_range(0, 99) != 0);
            r_we    = ($urandom_range(0, 9) == 0);
            r_stl   = ($urandom_range(0, 3) == 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
            r_rpc   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            applyStimulus("rand", r_rst, r_we, r_addr, 16'($urandom), r_stl, r_redir, r_rpc);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
